hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports: IFtoID_Op / IFtoID_Rs / IFtoID_Rt, input, 6/5/5, opcode and source registers of the instruction in ID.
REQ-004 SHALL have ports: branch_equal, input, 1, ID-stage register compare result (RD1 == RD2).
REQ-005 SHALL have ports: IDtoEX_MemRead / IDtoEX_RegWrite / IDtoEX_WriteReg, input, 1/1/5, load flag, writeback flag and destination of the instruction in EX.
REQ-006 SHALL have ports: EXtoMEM_RegWrite / EXtoMEM_WriteReg, input, 1/5, writeback flag and destination of the instruction in MEM.
REQ-007 SHALL have ports: cnt_clr, input, 1, synchronous clear of both counters.
REQ-008 SHALL have ports: PCWrite / IFtoID_Write, output, 1/1, PC and IF/ID register load enables.
REQ-009 SHALL have ports: ID_Bubble, output, 1, zero the ID/EX control fields.
REQ-010 SHALL have ports: PCSrc / IF_Flush, output, 1/1, select Branch_Addr and squash the IF/ID register.
REQ-011 SHALL have ports: stall_cnt / flush_cnt, output, 16/16, saturating performance counters.

Function
REQ-012 SHALL have three states: INIT, RUN and HOLD.
REQ-013 INIT SHALL last exactly one cycle and drive PCWrite=0, IFtoID_Write=0, ID_Bubble=1, PCSrc=0, IF_Flush=0, then go to RUN.
REQ-014 Source usage SHALL be decided by opcode:
- rs used for 6'h00 (R-type), 6'h23 (lw), 6'h2B (sw), 6'h04 (beq), 6'h05 (bne), 6'h08 (addi).
- rt used for 6'h00, 6'h2B, 6'h04, 6'h05.
- A match against register 0 SHALL never count as a hazard.
REQ-015 Load-use hazard SHALL be IDtoEX_MemRead=1 and IDtoEX_WriteReg matching a used source, for a non-branch ID opcode; stall length 1.
REQ-016 For a branch in ID (beq/bne), the hazard SHALL be:
- EX-producer (IDtoEX_RegWrite=1 and destination matches rs or rt): stall length 2.
- Otherwise MEM-producer (EXtoMEM_RegWrite=1 and destination matches): stall length 1.
REQ-017 In RUN with a hazard, outputs SHALL be PCWrite=0, IFtoID_Write=0, ID_Bubble=1, PCSrc=0, IF_Flush=0.
- Length 2: next state HOLD.
- Length 1: remain in RUN.
REQ-018 HOLD SHALL drive the same outputs as a RUN stall, perform no hazard evaluation, and return to RUN after exactly one cycle.
REQ-019 In RUN without a hazard, outputs SHALL be PCWrite=1, IFtoID_Write=1, ID_Bubble=0.
- Taken branch (beq with branch_equal=1, or bne with branch_equal=0): PCSrc=1 and IF_Flush=1 in the same cycle.
- Otherwise: PCSrc=0 and IF_Flush=0.
REQ-020 A taken-branch decision SHALL never be made while a hazard is active; stall has priority over flush.
REQ-021 stall_cnt SHALL increment once per cycle with ID_Bubble=1 in RUN or HOLD, and hold at 16'hFFFF.
REQ-022 flush_cnt SHALL increment once per cycle with IF_Flush=1, and hold at 16'hFFFF.
REQ-023 When cnt_clr=1 and an increment condition coincide, the counter SHALL be 0 on the next cycle.

Reset
REQ-024 While rst=1, the block SHALL drive PCWrite=0, IFtoID_Write=0, ID_Bubble=1, PCSrc=0, IF_Flush=0.
REQ-025 The first rising edge with rst=1 SHALL set state=INIT and both counters to 0.
REQ-026 Reset asserted in HOLD SHALL abandon the stall with no residual effect after INIT.

Structure
REQ-027 Opcode constants (R-type, lw, sw, beq, bne, addi) and state encodings SHALL live in the shared CPU package.
REQ-028 Source-usage decode and register-match logic SHALL be a combinational sub-module hazard_detect, outputting hazard and stall-length; hazard_ctrl holds the FSM and counters.

Verification
REQ-029 lw $8 in EX (MemRead=1, WriteReg=8); add using rs=8 in ID -> one cycle with PCWrite=0, ID_Bubble=1; next cycle PCWrite=1; stall_cnt=1.
REQ-030 add $9 in EX (RegWrite=1, WriteReg=9); beq rs=9 in ID -> two stall cycles (RUN, then HOLD); third cycle evaluates branch_equal; stall_cnt=2.
REQ-031 beq in ID, no hazard, branch_equal=1 -> PCSrc=1, IF_Flush=1 for one cycle; flush_cnt=1.
- Same case with bne -> PCSrc=0, IF_Flush=0.
REQ-032 lw $0 in EX; add using rs=0 in ID -> no stall; PCWrite=1.
REQ-033 rst pulsed during HOLD -> reset output values, then one INIT cycle, then RUN; counters 0.
REQ-034 Preload stall_cnt=16'hFFFF via forced stalls -> stays 16'hFFFF; cnt_clr with a concurrent stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU constants for the hazard controller: opcodes, FSM states and stall lengths.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_ONE  = 2'd1;
  localparam logic [1:0] LEN_TWO  = 2'd2;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller: ID/EX/MEM status in, stall/flush controls out.
interface hazard_ctrl_if;

  logic [5:0] IFtoID_Op;
  logic [4:0] IFtoID_Rs;
  logic [4:0] IFtoID_Rt;
  logic       branch_equal;
  logic       IDtoEX_MemRead;
  logic       IDtoEX_RegWrite;
  logic [4:0] IDtoEX_WriteReg;
  logic       EXtoMEM_RegWrite;
  logic [4:0] EXtoMEM_WriteReg;

  logic       PCWrite;
  logic       IFtoID_Write;
  logic       ID_Bubble;
  logic       PCSrc;
  logic       IF_Flush;

  modport master (
    output IFtoID_Op, IFtoID_Rs, IFtoID_Rt, branch_equal,
           IDtoEX_MemRead, IDtoEX_RegWrite, IDtoEX_WriteReg,
           EXtoMEM_RegWrite, EXtoMEM_WriteReg,
    input  PCWrite, IFtoID_Write, ID_Bubble, PCSrc, IF_Flush
  );

  modport slave (
    input  IFtoID_Op, IFtoID_Rs, IFtoID_Rt, branch_equal,
           IDtoEX_MemRead, IDtoEX_RegWrite, IDtoEX_WriteReg,
           EXtoMEM_RegWrite, EXtoMEM_WriteReg,
    output PCWrite, IFtoID_Write, ID_Bubble, PCSrc, IF_Flush
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard detection: decides which sources the ID instruction reads and
// whether an in-flight producer forces a stall, and for how many cycles.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_write_reg,
  output logic       hazard,
  output logic [1:0] stall_len
);

  logic use_rs;
  logic use_rt;
  logic branch;
  logic ex_match;
  logic mem_match;

  always_comb begin
    use_rs = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI);
    use_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    branch = is_branch(op);

    // $0 is hard-wired, so a producer targeting it never creates a dependency
    ex_match  = (ex_write_reg != 5'd0) &&
                ((use_rs && (ex_write_reg == rs)) || (use_rt && (ex_write_reg == rt)));
    mem_match = (mem_write_reg != 5'd0) &&
                ((use_rs && (mem_write_reg == rs)) || (use_rt && (mem_write_reg == rt)));

    stall_len = LEN_NONE;
    if (branch) begin
      // Branches resolve in ID, so ALU results still in flight must drain first
      if (ex_reg_write && ex_match)
        stall_len = LEN_TWO;
      else if (mem_reg_write && mem_match)
        stall_len = LEN_ONE;
    end else if (ex_mem_read && ex_match) begin
      stall_len = LEN_ONE;
    end

    hazard = (stall_len != LEN_NONE);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: INIT/RUN/HOLD sequencer driving PC/IF-ID stalls and branch flushes,
// plus saturating stall and flush performance counters.
//
// state | meaning
// INIT  | one-cycle post-reset settle, pipeline held with a bubble
// RUN   | normal issue; evaluates hazards and taken branches
// HOLD  | second cycle of a two-cycle branch stall, no evaluation
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      bus,
  input  logic              cnt_clr,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic       hazard;
  logic [1:0] stall_len;
  logic       taken;
  logic       pc_write;
  logic       ifid_write;
  logic       bubble;
  logic       pc_src;
  logic       if_flush;
  logic       inc_stall;
  logic       inc_flush;

  hazard_detect u_detect (
    .op            (bus.IFtoID_Op),
    .rs            (bus.IFtoID_Rs),
    .rt            (bus.IFtoID_Rt),
    .ex_mem_read   (bus.IDtoEX_MemRead),
    .ex_reg_write  (bus.IDtoEX_RegWrite),
    .ex_write_reg  (bus.IDtoEX_WriteReg),
    .mem_reg_write (bus.EXtoMEM_RegWrite),
    .mem_write_reg (bus.EXtoMEM_WriteReg),
    .hazard        (hazard),
    .stall_len     (stall_len)
  );

  assign taken = ((bus.IFtoID_Op == OP_BEQ) &&  bus.branch_equal) ||
                 ((bus.IFtoID_Op == OP_BNE) && !bus.branch_equal);

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    bubble     = 1'b1;
    pc_src     = 1'b0;
    if_flush   = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_INIT: state_nxt = ST_RUN;
        ST_RUN: begin
          if (hazard) begin
            inc_stall = 1'b1;
            if (stall_len == LEN_TWO)
              state_nxt = ST_HOLD;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            bubble     = 1'b0;
            if (taken) begin
              pc_src    = 1'b1;
              if_flush  = 1'b1;
              inc_flush = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          inc_stall = 1'b1;
          state_nxt = ST_RUN;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        stall_cnt <= 16'd0;
      else if (inc_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 16'd1;
      if (cnt_clr)
        flush_cnt <= 16'd0;
      else if (inc_flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IFtoID_Write = ifid_write;
  assign bus.ID_Bubble    = bubble;
  assign bus.PCSrc        = pc_src;
  assign bus.IF_Flush     = if_flush;

endmodule
